// File: rtl/sd_xfer_sched_if.sv
// Signal bundle between the transfer scheduler, the USB FIFO side and the SD host.
// The master modport is the scheduler; the slave modport is its environment.
interface sd_xfer_sched_if #(
  parameter int ADDR_W = 16
);
  logic              out_rdy;
  logic              in_req;
  logic              rd_fifo_empty;
  logic              sd_done;
  logic              sd_crc_ok;
  logic              err_clr;
  logic              sd_wr_start;
  logic              sd_rd_start;
  logic [ADDR_W-1:0] sd_blk_addr;
  logic              out_done;
  logic              in_done;
  logic              busy;
  logic              err;

  modport master (
    input  out_rdy, in_req, rd_fifo_empty, sd_done, sd_crc_ok, err_clr,
    output sd_wr_start, sd_rd_start, sd_blk_addr, out_done, in_done, busy, err
  );

  modport slave (
    output out_rdy, in_req, rd_fifo_empty, sd_done, sd_crc_ok, err_clr,
    input  sd_wr_start, sd_rd_start, sd_blk_addr, out_done, in_done, busy, err
  );
endinterface

// File: rtl/sd_xfer_sched.sv
// Arbitrates the single SD port between the USB OUT (write) and IN (read) paths,
// one block at a time, with write CRC retries and a hung-card timeout.
module sd_xfer_sched #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY   = 3
) (
  input logic            clk,
  input logic            n_rst,
  sd_xfer_sched_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR_ST = 3'd1;
  localparam logic [2:0] WR_WT = 3'd2;
  localparam logic [2:0] RD_ST = 3'd3;
  localparam logic [2:0] RD_WT = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] blk_addr;
  logic [RW-1:0]     retry;
  logic [TW-1:0]     timer;
  logic              last_in;
  logic              out_done_q;
  logic              in_done_q;

  logic out_elig;
  logic in_elig;
  logic grant_wr;
  logic grant_rd;
  logic timed_out;

  always_comb begin
    out_elig  = bus.out_rdy;
    in_elig   = bus.in_req & bus.rd_fifo_empty;
    // On contention the direction not served last wins.
    grant_wr  = out_elig & (~in_elig | last_in);
    grant_rd  = in_elig & (~out_elig | ~last_in);
    timed_out = (timer == TW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      blk_addr   <= '0;
      retry      <= '0;
      timer      <= '0;
      last_in    <= 1'b1;
      out_done_q <= 1'b0;
      in_done_q  <= 1'b0;
    end else begin
      out_done_q <= 1'b0;
      in_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state    <= WR_ST;
            last_in  <= 1'b0;
            blk_addr <= wr_addr;
          end else if (grant_rd) begin
            state    <= RD_ST;
            last_in  <= 1'b1;
            blk_addr <= rd_addr;
          end
        end
        WR_ST: begin
          timer <= '0;
          state <= WR_WT;
        end
        RD_ST: begin
          timer <= '0;
          state <= RD_WT;
        end
        // sd_done is checked before the timeout so a completion in the final
        // waiting cycle still counts.
        WR_WT: begin
          if (bus.sd_done) begin
            if (bus.sd_crc_ok) begin
              out_done_q <= 1'b1;
              wr_addr    <= wr_addr + 1'b1;
              retry      <= '0;
              state      <= IDLE;
            end else if (retry < RW'(MAX_RETRY)) begin
              retry    <= retry + 1'b1;
              blk_addr <= wr_addr;
              state    <= WR_ST;
            end else begin
              state <= ERR;
            end
          end else if (timed_out) begin
            state <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RD_WT: begin
          if (bus.sd_done) begin
            in_done_q <= 1'b1;
            rd_addr   <= rd_addr + 1'b1;
            state     <= IDLE;
          end else if (timed_out) begin
            state <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ERR: begin
          if (bus.err_clr) begin
            retry <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.sd_wr_start = (state == WR_ST);
    bus.sd_rd_start = (state == RD_ST);
    bus.sd_blk_addr = blk_addr;
    bus.out_done    = out_done_q;
    bus.in_done     = in_done_q;
    bus.busy        = (state != IDLE) && (state != ERR);
    bus.err         = (state == ERR);
  end
endmodule

// File: tb/tb_sd_xfer_sched.sv
// Directed bench for sd_xfer_sched: expected start pulses go into a scoreboard
// queue and are checked as the scheduler issues them.
module tb_sd_xfer_sched;
  logic clk;
  logic n_rst;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  sd_xfer_sched_if #(.ADDR_W(2)) ifc ();

  sd_xfer_sched #(
    .ADDR_W(2),
    .TIMEOUT_CYC(20),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic await_start(input string tag);
    int n;
    n = 0;
    while (!(ifc.sd_wr_start || ifc.sd_rd_start) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, 32'(n < 40), 1);
  endtask

  task automatic done_pulse(input logic crc);
    ifc.sd_done   = 1'b1;
    ifc.sd_crc_ok = crc;
    @(negedge clk);
    ifc.sd_done   = 1'b0;
    ifc.sd_crc_ok = 1'b0;
  endtask

  task automatic push(input logic wr, input logic [1:0] addr);
    exp_t e;
    e.wr   = wr;
    e.addr = addr;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (n_rst && (ifc.sd_wr_start || ifc.sd_rd_start)) begin
      if (q.size() == 0) begin
        chk("start_unexpected", {30'd0, ifc.sd_wr_start, ifc.sd_rd_start}, 0);
      end else begin
        mon_e = q.pop_front();
        chk("start_is_wr", ifc.sd_wr_start, mon_e.wr);
        chk("start_is_rd", ifc.sd_rd_start, !mon_e.wr);
        chk("start_addr", ifc.sd_blk_addr, mon_e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst             = 1'b0;
    ifc.out_rdy       = 1'b1;
    ifc.in_req        = 1'b0;
    ifc.rd_fifo_empty = 1'b0;
    ifc.sd_done       = 1'b0;
    ifc.sd_crc_ok     = 1'b0;
    ifc.err_clr       = 1'b0;
    cycles(2);
    chk("rst_wr_start", ifc.sd_wr_start, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_addr", ifc.sd_blk_addr, 0);
    chk("rst_out_done", ifc.out_done, 0);

    // single OUT block
    push(1'b1, 2'd0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("t1_latency", ifc.sd_wr_start, 1);
    ifc.out_rdy = 1'b0;
    cycles(10);
    chk("t1_busy_wait", ifc.busy, 1);
    done_pulse(1'b1);
    chk("t1_out_done", ifc.out_done, 1);
    chk("t1_busy_idle", ifc.busy, 0);
    cycles(1);
    chk("t1_out_done_pulse", ifc.out_done, 0);
    push(1'b1, 2'd1);
    ifc.out_rdy = 1'b1;
    await_start("t1_second");
    ifc.out_rdy = 1'b0;
    cycles(3);
    done_pulse(1'b1);

    // contention, fresh reset so OUT wins first
    n_rst = 1'b0;
    cycles(1);
    n_rst = 1'b1;
    push(1'b1, 2'd0);
    push(1'b0, 2'd0);
    push(1'b1, 2'd1);
    push(1'b0, 2'd1);
    ifc.out_rdy       = 1'b1;
    ifc.in_req        = 1'b1;
    ifc.rd_fifo_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      await_start("t2_op");
      cycles(3);
      done_pulse(1'b1);
      if (i % 2 == 0) chk("t2_out_done", ifc.out_done, 1);
      else chk("t2_in_done", ifc.in_done, 1);
    end
    ifc.out_rdy = 1'b0;
    ifc.in_req  = 1'b0;

    // CRC retry that recovers on the third attempt
    push(1'b1, 2'd2);
    push(1'b1, 2'd2);
    push(1'b1, 2'd2);
    ifc.out_rdy = 1'b1;
    await_start("t3_first");
    ifc.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycles(2);
      done_pulse(i == 2);
      if (i < 2) chk("t3_retry_start", ifc.sd_wr_start, 1);
    end
    chk("t3_out_done", ifc.out_done, 1);
    chk("t3_err", ifc.err, 0);

    // four consecutive failures end in ERR
    for (int i = 0; i < 4; i++) push(1'b1, 2'd3);
    ifc.out_rdy = 1'b1;
    await_start("t3b_first");
    ifc.out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycles(2);
      done_pulse(1'b0);
      if (i < 3) chk("t3b_retry_start", ifc.sd_wr_start, 1);
    end
    chk("t3b_err", ifc.err, 1);
    chk("t3b_busy", ifc.busy, 0);
    ifc.out_rdy = 1'b1;
    cycles(3);
    done_pulse(1'b1);
    chk("t3b_done_in_err", ifc.out_done, 0);
    chk("t3b_err_sticky", ifc.err, 1);
    ifc.out_rdy = 1'b0;
    ifc.err_clr = 1'b1;
    @(negedge clk);
    ifc.err_clr = 1'b0;
    chk("t3b_err_clr", ifc.err, 0);

    // read timeout, then the same rd address is reused
    push(1'b0, 2'd2);
    ifc.in_req = 1'b1;
    await_start("t4_read");
    ifc.in_req = 1'b0;
    cycles(20);
    chk("t4_err_before", ifc.err, 0);
    chk("t4_busy_before", ifc.busy, 1);
    cycles(1);
    chk("t4_err_timeout", ifc.err, 1);
    ifc.err_clr = 1'b1;
    @(negedge clk);
    ifc.err_clr = 1'b0;
    chk("t4_err_clr", ifc.err, 0);
    push(1'b0, 2'd2);
    ifc.in_req = 1'b1;
    await_start("t4_reread");
    ifc.in_req = 1'b0;
    cycles(3);
    done_pulse(1'b1);
    chk("t4_in_done", ifc.in_done, 1);

    // completion in the final waiting cycle beats the timeout
    push(1'b0, 2'd3);
    ifc.in_req = 1'b1;
    await_start("t4b_read");
    ifc.in_req = 1'b0;
    cycles(20);
    done_pulse(1'b0);
    chk("t4b_in_done", ifc.in_done, 1);
    chk("t4b_err", ifc.err, 0);

    // address wrap over five reads
    push(1'b0, 2'd0);
    push(1'b0, 2'd1);
    push(1'b0, 2'd2);
    push(1'b0, 2'd3);
    push(1'b0, 2'd0);
    ifc.in_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      await_start("t5_read");
      cycles(2);
      done_pulse(1'b1);
    end
    ifc.in_req = 1'b0;

    // IN gated by a non-empty read FIFO
    ifc.rd_fifo_empty = 1'b0;
    ifc.in_req        = 1'b1;
    cycles(8);
    chk("t5_gated_busy", ifc.busy, 0);
    ifc.in_req = 1'b0;

    // asynchronous reset mid-write
    push(1'b1, 2'd3);
    ifc.out_rdy = 1'b1;
    await_start("t6_write");
    ifc.out_rdy = 1'b0;
    cycles(3);
    n_rst = 1'b0;
    #1;
    chk("t6_busy", ifc.busy, 0);
    chk("t6_addr", ifc.sd_blk_addr, 0);
    chk("t6_wr_start", ifc.sd_wr_start, 0);
    cycles(2);
    n_rst = 1'b1;
    done_pulse(1'b1);
    chk("t6_no_out_done", ifc.out_done, 0);
    push(1'b1, 2'd0);
    ifc.out_rdy = 1'b1;
    await_start("t6_after");
    ifc.out_rdy = 1'b0;
    cycles(2);
    done_pulse(1'b1);
    chk("t6_out_done", ifc.out_done, 1);

    cycles(2);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_xfer_sched.md
Name: sd_xfer_sched

Overview:
- Arbiter and sequencer for the single SD card port, shared between the USB OUT path and the USB IN path.
- OUT path: drains the full write FIFO to the SD card.
- IN path: refills the empty read FIFO from the SD card.
- Issues one SD block operation at a time, tracks per-direction block addresses, retries failed writes and times out a hung card. Sits between the USB top-level FIFOs/controller and the SD host interface.

Parameters:
- ADDR_W, 16, width of the SD block address counters.
- TIMEOUT_CYC, 65535, max cycles to wait for sd_done before declaring a timeout.
- MAX_RETRY, 3, write retries after a CRC failure before raising err.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- out_rdy  in  1  write FIFO full; an OUT block is ready for SD.
- in_req  in  1  host IN transfer pending (level).
- rd_fifo_empty  in  1  read FIFO empty; room for one block.
- sd_done  in  1  one-cycle pulse: SD operation finished.
- sd_crc_ok  in  1  CRC status, sampled only with sd_done.
- err_clr  in  1  clears err and returns to IDLE.
- sd_wr_start  out  1  one-cycle pulse: start SD block write.
- sd_rd_start  out  1  one-cycle pulse: start SD block read.
- sd_blk_addr  out  ADDR_W  block address for the current operation.
- out_done  out  1  one-cycle pulse: OUT block committed to SD.
- in_done  out  1  one-cycle pulse: IN block loaded into read FIFO.
- busy  out  1  high in any state other than IDLE and ERR.
- err  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous. All outputs go to 0, wr_addr=0, rd_addr=0, retry=0, timer=0, last_grant=IN (so OUT wins first), state=IDLE.
- States: IDLE, WR_ST, WR_WT, RD_ST, RD_WT, ERR.

Arbitration in IDLE:
- OUT is eligible when out_rdy=1.
- IN is eligible when in_req=1 and rd_fifo_empty=1.
- If both are eligible, grant the direction that is not last_grant, then update last_grant.
- If neither is eligible, stay in IDLE.

Write sequence:
- WR_ST lasts one cycle: sd_wr_start=1, sd_blk_addr=wr_addr, timer cleared. Next state WR_WT.
- In WR_WT the timer increments each cycle.
- On sd_done with sd_crc_ok=1: pulse out_done next cycle, wr_addr+1 (wraps modulo 2^ADDR_W), retry=0, go to IDLE.
- On sd_done with sd_crc_ok=0:
  - if retry<MAX_RETRY: retry+1, back to WR_ST with the same address;
  - otherwise go to ERR.

Read sequence:
- RD_ST lasts one cycle: sd_rd_start=1, sd_blk_addr=rd_addr. Next state RD_WT.
- On sd_done: pulse in_done, rd_addr+1 (wraps), go to IDLE.
- sd_crc_ok is ignored on reads; the rx path handles NAK.

Timing and addressing:
- Latency from eligible request to start pulse: IDLE→*_ST takes 1 clock, so the start pulse is asserted in the 2nd cycle after the request is sampled.
- sd_blk_addr holds its value from *_ST until the next *_ST.

Timeout:
- In WR_WT or RD_WT, if timer reaches TIMEOUT_CYC with no sd_done, go to ERR.
- sd_done arriving in that same cycle takes precedence over the timeout.

Error handling:
- On entering ERR: err=1, busy=0; no starts issued while in ERR.
- err_clr in ERR returns to IDLE next cycle and clears err and retry. Addresses are kept.
- err_clr outside ERR is ignored.

Other boundary rules:
- sd_done in IDLE, *_ST or ERR is ignored.
- Requests that drop while an operation is in flight do not abort it.
- Async reset mid-operation leaves no pending start pulse and clears the addresses.

Test Plan:
1. Single OUT: out_rdy=1 from reset → sd_wr_start pulse with addr 0; sd_done+crc_ok 10 cycles later → out_done pulse, then the next write uses addr 1, busy low.
2. Contention: out_rdy=1, in_req=1, rd_fifo_empty=1 held for 4 completed ops → grant order WR0, RD0, WR1, RD1; addresses wr 0,1 and rd 0,1.
3. CRC retry: MAX_RETRY=3; first two sd_done with crc_ok=0, third with crc_ok=1 → three sd_wr_start pulses all at the same addr, one out_done, err stays 0. A 4th consecutive failure case → err=1 after the 4th failure.
4. Timeout: TIMEOUT_CYC=20, no sd_done after sd_rd_start → err=1 at cycle 20; err_clr → IDLE, next read uses the same rd_addr.
5. Wrap and gating: ADDR_W=2, 5 reads → addresses 0,1,2,3,0. in_req with rd_fifo_empty=0 → no sd_rd_start issued.
6. Reset mid-op: assert n_rst in WR_WT → all outputs 0 immediately, addresses 0; a later sd_done produces no out_done.
